// File: rtl/bcd2bin_16.sv
// bcd2bin_16: iterative 5-digit BCD to binary converter (reverse double-dabble, one step per clock)
module bcd2bin_16 #(
  parameter int N_DIGITS = 5,
  parameter int BIN_W    = 17
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [4*N_DIGITS-1:0]   bcd_in,
  output logic [BIN_W-1:0]        bin_out,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);
  localparam int W  = 4 * N_DIGITS;
  localparam int CW = $clog2(W + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;
  state_t         state_q;
  logic [W-1:0]   bcd_q, bin_q, bcd_sh, bcd_d, bin_d;
  logic [CW-1:0]  cnt_q;
  logic           inv_q, in_bad;
  assign bcd_sh = bcd_q >> 1;
  assign bin_d  = {bcd_q[0], bin_q[W-1:1]};
  // Flag any incoming digit outside 0..9
  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) in_bad = in_bad | (bcd_in[4*i+:4] > 4'd9);
  end
  // One reverse double-dabble step: shifted digits of 8 or more lose 3
  always_comb begin
    bcd_d = bcd_sh;
    for (int i = 0; i < N_DIGITS; i++)
      bcd_d[4*i+:4] = (bcd_sh[4*i+:4] >= 4'd8) ? bcd_sh[4*i+:4] - 4'd3 : bcd_sh[4*i+:4];
  end
  // Control FSM with datapath registers and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      inv_q   <= 1'b0;
      bin_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          bcd_q   <= bcd_in;
          bin_q   <= '0;
          inv_q   <= in_bad;
          cnt_q   <= in_bad ? '0 : CW'(W);
          busy    <= 1'b1;
          state_q <= in_bad ? FINISH : SHIFT;
        end
        SHIFT: begin
          bcd_q   <= bcd_d;
          bin_q   <= bin_d;
          cnt_q   <= cnt_q - 1'b1;
          state_q <= (cnt_q == CW'(1)) ? FINISH : SHIFT;
        end
        FINISH: begin
          bin_out <= inv_q ? '0 : bin_q[BIN_W-1:0];
          err     <= inv_q;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // Valid BCD never produces bits above BIN_W; done and busy are exclusive
  a_no_ovf: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == FINISH && !inv_q) |-> ((bin_q >> BIN_W) == '0));
  a_excl: assert property (@(posedge clk) disable iff (!rst_n) !(done && busy));
endmodule

// File: tb/tb_bcd2bin_16.sv
// tb_bcd2bin_16: directed self-checking bench for bcd2bin_16
module tb_bcd2bin_16;
  localparam int BIN_W = 17;
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [19:0]      bcd_in = '0;
  logic [BIN_W-1:0] bin_out;
  logic             busy, done, err;
  int checks = 0;
  int failures = 0;

  bcd2bin_16 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in),
    .bin_out(bin_out), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Issue a one-cycle start, scramble bcd_in afterwards, and wait for done.
  task automatic run_conv(input logic [19:0] v, output int lat, output int bc,
                          output logic [BIN_W-1:0] b, output logic e);
    @(negedge clk); bcd_in = v; start = 1'b1;
    @(negedge clk); start = 1'b0; bcd_in = 20'hFFFFF;
    lat = 0; bc = 0;
    while (!done && lat < 40) begin
      if (busy) bc++;
      @(negedge clk); lat++;
    end
    b = bin_out; e = err;
  endtask

  task automatic test_reset();
    logic bad;
    rst_n = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bin_out !== '0) begin failures++; $display("FAIL reset_bin got=%h exp=0", bin_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bin_out !== '0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin failures++; $display("FAIL reset_static got=changed exp=static"); end
  endtask

  task automatic test_basic();
    int lat, bc; logic [BIN_W-1:0] b; logic e;
    run_conv(20'h12345, lat, bc, b, e);
    checks++; if (lat != 21) begin failures++; $display("FAIL basic_latency got=%0d exp=21", lat); end
    checks++; if (bc != 21) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=21", bc); end
    checks++; if (b !== 17'h03039) begin failures++; $display("FAIL basic_bin got=%h exp=03039", b); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL basic_err got=%b exp=0", e); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_at_done got=%b exp=0", busy); end
    repeat (3) @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    checks++; if (bin_out !== 17'h03039) begin failures++; $display("FAIL basic_hold got=%h exp=03039", bin_out); end
  endtask

  task automatic test_boundary();
    logic [19:0]      vin [4] = '{20'h99999, 20'h00000, 20'h00999, 20'h10000};
    logic [BIN_W-1:0] vexp[4] = '{17'h1869F, 17'h00000, 17'h003E7, 17'h02710};
    int lat, bc; logic [BIN_W-1:0] b; logic e;
    for (int i = 0; i < 4; i++) begin
      run_conv(vin[i], lat, bc, b, e);
      checks++; if (b !== vexp[i] || e !== 1'b0) begin failures++; $display("FAIL boundary_%h got=%h/%b exp=%h/0", vin[i], b, e, vexp[i]); end
      checks++; if (lat != 21) begin failures++; $display("FAIL boundary_lat_%h got=%0d exp=21", vin[i], lat); end
    end
  endtask

  task automatic test_invalid();
    int lat, bc; logic [BIN_W-1:0] b; logic e;
    run_conv(20'h1A345, lat, bc, b, e);
    checks++; if (lat != 1) begin failures++; $display("FAIL invalid_latency got=%0d exp=1", lat); end
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL invalid_err got=%b exp=1", e); end
    checks++; if (b !== '0) begin failures++; $display("FAIL invalid_bin got=%h exp=0", b); end
    run_conv(20'h00042, lat, bc, b, e);
    checks++; if (b !== 17'd42) begin failures++; $display("FAIL after_invalid_bin got=%0d exp=42", b); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL after_invalid_err got=%b exp=0", e); end
  endtask

  task automatic test_busy_start();
    int lat, bc; logic [BIN_W-1:0] b; logic e;
    @(negedge clk); bcd_in = 20'h00500; start = 1'b1;
    @(negedge clk); start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk); lat++;
      if (lat == 5) begin bcd_in = 20'h00777; start = 1'b1; end
      else start = 1'b0;
    end
    checks++; if (lat != 21) begin failures++; $display("FAIL busy_start_latency got=%0d exp=21", lat); end
    checks++; if (bin_out !== 17'd500) begin failures++; $display("FAIL busy_start_bin got=%0d exp=500", bin_out); end
    run_conv(20'h00777, lat, bc, b, e);
    checks++; if (b !== 17'd777 || lat != 21) begin failures++; $display("FAIL busy_start_next got=%0d lat=%0d exp=777 lat=21", b, lat); end
  endtask

  task automatic test_back_to_back();
    int t, t1, t2;
    @(negedge clk); bcd_in = 20'h00321; start = 1'b1;
    t = 0; t1 = -1; t2 = -1;
    while (t2 < 0 && t < 100) begin
      @(negedge clk); t++;
      if (done) begin
        if (t1 < 0) t1 = t;
        else begin t2 = t; start = 1'b0; end
      end
    end
    start = 1'b0;
    checks++; if (t2 - t1 != 22) begin failures++; $display("FAIL b2b_period got=%0d exp=22", t2 - t1); end
    checks++; if (bin_out !== 17'd321) begin failures++; $display("FAIL b2b_bin got=%0d exp=321", bin_out); end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_abort();
    int lat, bc; logic [BIN_W-1:0] b; logic e; logic saw;
    @(negedge clk); bcd_in = 20'h54321; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (bin_out !== '0) begin failures++; $display("FAIL abort_bin got=%h exp=0", bin_out); end
    @(negedge clk); rst_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) saw = 1'b1;
    end
    checks++; if (saw) begin failures++; $display("FAIL abort_done got=pulse exp=none"); end
    run_conv(20'h00007, lat, bc, b, e);
    checks++; if (b !== 17'd7 || e !== 1'b0) begin failures++; $display("FAIL abort_next got=%0d/%b exp=7/0", b, e); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_invalid();
    test_busy_start();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
